// File: rtl/switch_in.sv
// Debounced switch/button input block with a CPU register interface.
// Raw inputs are synchronized, debounced by one shared hold counter, and reported via STABLE/STATUS/MASK and Irq.

module switch_in_lane (
    input  logic Clk,
    input  logic Reset,
    input  logic sw,
    input  logic commit,
    input  logic clr,
    input  logic mask_we,
    input  logic wd,
    output logic diff,
    output logic stable,
    output logic status,
    output logic mask
);
    logic sync1, sync2, cand;

    // cand always tracks sync2; a mismatch is what restarts the shared counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cand   <= 1'b0;
            stable <= 1'b0;
            status <= 1'b0;
            mask   <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            cand  <= sync2;
            if (commit)
                stable <= cand;
            // a set on the same edge as a clear wins
            status <= (status & ~clr) | (commit & (stable ^ cand));
            if (mask_we)
                mask <= wd;
        end
    end

    assign diff = sync2 ^ cand;
endmodule

module switch_in #(
    parameter int WIDTH     = 32,
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [1:0]       Addr,
    input  logic [31:0]      Wd,
    input  logic             We,
    output logic [31:0]      Rd,
    output logic             Irq
);
    logic [WIDTH-1:0] diff, stable, status, mask, clr;
    logic [CNT_W-1:0] cnt;
    logic             quiet, at_top, commit, status_we, mask_we;

    assign quiet     = ~|diff;
    assign at_top    = (cnt == CNT_W'(DB_CYCLES - 1));
    assign commit    = quiet & at_top;
    assign status_we = We & (Addr == 2'd1);
    assign mask_we   = We & (Addr == 2'd2);
    assign clr       = status_we ? Wd[WIDTH-1:0] : '0;

    // shared hold counter: any bit moving restarts it, saturates once all bits are quiet
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else if (!quiet)
            cnt <= '0;
        else if (!at_top)
            cnt <= cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        switch_in_lane u_lane (
            .Clk     (Clk),
            .Reset   (Reset),
            .sw      (sw_in[i]),
            .commit  (commit),
            .clr     (clr[i]),
            .mask_we (mask_we),
            .wd      (Wd[i]),
            .diff    (diff[i]),
            .stable  (stable[i]),
            .status  (status[i]),
            .mask    (mask[i])
        );
    end

    if (WIDTH < 32) begin : g_wd_hi
        logic unused_wd_hi;
        assign unused_wd_hi = |Wd[31:WIDTH];
    end

    always_comb begin
        Rd = '0;
        case (Addr)
            2'd0:    Rd[WIDTH-1:0] = stable;
            2'd1:    Rd[WIDTH-1:0] = status;
            2'd2:    Rd[WIDTH-1:0] = mask;
            default: Rd = '0;
        endcase
    end

    assign Irq = |(status & mask);
endmodule

// File: tb/tb_switch_in.sv
// Directed bench for switch_in with WIDTH=8, DB_CYCLES=4: vector table plus hand sequences for toggling and mid-debounce reset.

module tb_switch_in;
    logic        Clk, Reset;
    logic [7:0]  sw_in;
    logic [1:0]  Addr;
    logic [31:0] Wd;
    logic        We;
    logic [31:0] Rd;
    logic        Irq;

    int n_cmp = 0;
    int n_bad = 0;

    switch_in #(.WIDTH(8), .DB_CYCLES(4), .CNT_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sw_in (sw_in),
        .Addr  (Addr),
        .Wd    (Wd),
        .We    (We),
        .Rd    (Rd),
        .Irq   (Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [7:0]  sw;
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wd;
        int          cyc;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic [7:0] sw, logic we, logic [1:0] waddr,
                                logic [31:0] wd, int cyc, logic [1:0] raddr,
                                logic [31:0] exp_rd, logic exp_irq);
        vec_t v;
        v.name = name; v.sw = sw; v.we = we; v.waddr = waddr; v.wd = wd;
        v.cyc = cyc; v.raddr = raddr; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic rd_chk(string name, logic [1:0] a, logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Rd, exp);
    endtask

    initial begin
        Reset = 1'b0; sw_in = 8'h00; Addr = 2'd0; Wd = '0; We = 1'b0;

        // while held in reset
        #2;
        rd_chk("in_rst_stable", 2'd0, 32'h0);
        chk("in_rst_irq", {31'b0, Irq}, 32'h0);
        #21 Reset = 1'b1;
        tick(10);

        tbl.push_back(mk("rst_stable", 8'h00, 0, 0, 0,            0, 0, 32'h00, 0));
        tbl.push_back(mk("rst_status", 8'h00, 0, 0, 0,            0, 1, 32'h00, 0));
        tbl.push_back(mk("rst_mask",   8'h00, 0, 0, 0,            0, 2, 32'h00, 0));
        tbl.push_back(mk("rst_rsvd",   8'h00, 0, 0, 0,            0, 3, 32'h00, 0));
        tbl.push_back(mk("glitch_hi",  8'h01, 0, 0, 0,            3, 0, 32'h00, 0));
        tbl.push_back(mk("glitch_lo",  8'h00, 0, 0, 0,            8, 0, 32'h00, 0));
        tbl.push_back(mk("glitch_sts", 8'h00, 0, 0, 0,            0, 1, 32'h00, 0));
        tbl.push_back(mk("lat_6",      8'h05, 0, 0, 0,            6, 0, 32'h00, 0));
        tbl.push_back(mk("lat_7",      8'h05, 0, 0, 0,            1, 0, 32'h05, 0));
        tbl.push_back(mk("sts_set",    8'h05, 0, 0, 0,            0, 1, 32'h05, 0));
        tbl.push_back(mk("mask_wr",    8'h05, 1, 2, 32'hFFFFFF04, 1, 2, 32'h04, 1));
        tbl.push_back(mk("w1c",        8'h05, 1, 1, 32'h04,       1, 1, 32'h01, 0));
        tbl.push_back(mk("wr_a0",      8'h05, 1, 0, 32'hFF,       1, 0, 32'h05, 0));
        tbl.push_back(mk("wr_a3",      8'h05, 1, 3, 32'hFF,       1, 2, 32'h04, 0));
        tbl.push_back(mk("sts_keep",   8'h05, 0, 0, 0,            0, 1, 32'h01, 0));
        tbl.push_back(mk("mask_b0",    8'h05, 1, 2, 32'h01,       1, 1, 32'h01, 1));
        tbl.push_back(mk("pre_fall",   8'h04, 0, 0, 0,            6, 0, 32'h05, 1));
        tbl.push_back(mk("set_wins",   8'h04, 1, 1, 32'h01,       1, 1, 32'h01, 1));
        tbl.push_back(mk("stable_04",  8'h04, 0, 0, 0,            0, 0, 32'h04, 1));
        tbl.push_back(mk("w1c_b0",     8'h04, 1, 1, 32'h01,       1, 1, 32'h00, 0));

        foreach (tbl[i]) begin
            sw_in = tbl[i].sw;
            if (tbl[i].we) begin
                Addr = tbl[i].waddr;
                Wd   = tbl[i].wd;
                We   = 1'b1;
                tick(1);
                We   = 1'b0;
                tick(tbl[i].cyc - 1);
            end else begin
                tick(tbl[i].cyc);
            end
            rd_chk(tbl[i].name, tbl[i].raddr, tbl[i].exp_rd);
            chk({tbl[i].name, "_irq"}, {31'b0, Irq}, {31'b0, tbl[i].exp_irq});
        end

        // bit 3 chatters every 2 cycles while bit 1 rises and holds
        for (int i = 0; i < 6; i++) begin
            sw_in = (i % 2 != 0) ? 8'h0E : 8'h06;
            tick(2);
            rd_chk("chatter_hold", 2'd0, 32'h04);
        end
        sw_in = 8'h06;
        tick(6);
        rd_chk("chatter_q6", 2'd0, 32'h04);
        tick(1);
        rd_chk("chatter_q7", 2'd0, 32'h06);
        rd_chk("chatter_sts", 2'd1, 32'h02);

        Addr = 2'd2; Wd = 32'h02; We = 1'b1;
        tick(1);
        We = 1'b0;
        chk("irq_mask02", {31'b0, Irq}, 32'h1);

        // reset dropped asynchronously mid-debounce
        sw_in = 8'hF0;
        tick(3);
        #3 Reset = 1'b0;
        #1;
        chk("arst_irq", {31'b0, Irq}, 32'h0);
        rd_chk("arst_stable", 2'd0, 32'h0);
        rd_chk("arst_status", 2'd1, 32'h0);
        Addr = 2'd2; Wd = 32'hFF; We = 1'b1;
        @(posedge Clk);
        #1;
        chk("arst_wr_ignored", Rd, 32'h0);
        We = 1'b0;
        #3 Reset = 1'b1;
        tick(6);
        rd_chk("rerun_6", 2'd0, 32'h00);
        tick(1);
        rd_chk("rerun_7", 2'd0, 32'hF0);
        rd_chk("rerun_sts", 2'd1, 32'hF0);
        rd_chk("rerun_mask", 2'd2, 32'h00);
        chk("rerun_irq", {31'b0, Irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/switch_in.md
SWITCH_IN -- requirements
Module: switch_in

Interface
REQ-001 Parameters: WIDTH, default 32, number of switch/button inputs (1..32); DB_CYCLES, default 20000, debounce hold time in Clk cycles (>=2); CNT_W, default 16, debounce counter width (2^CNT_W > DB_CYCLES).
REQ-002 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clk.
REQ-004 sw_in  input  WIDTH  raw, asynchronous, bouncing switch/button levels.
REQ-005 Addr  input  2  register select: 0=STABLE (read-only), 1=STATUS (read, write-1-to-clear), 2=MASK (read/write), 3=reserved.
REQ-006 Wd  input  32  CPU write data.
REQ-007 We  input  1  CPU write enable, sampled on posedge Clk.
REQ-008 Rd  output  32  CPU read data, combinational from Addr.
REQ-009 Irq  output  1  level interrupt request to CPU.

Function
REQ-010 Synchronizer: sw_in passes through two flops (sync1, sync2) before any other use.
REQ-011 Debounce, evaluated each posedge, single shared counter cnt and register cand[WIDTH]:
- sync2 != cand: cand<=sync2, cnt<=0.
- else cnt==DB_CYCLES-1: stable<=cand, cnt holds.
- else: cnt<=cnt+1.
REQ-012 Latency: an input change held constant reaches stable at posedge DB_CYCLES+3 counted from the first posedge after the change.
REQ-013 Any bit changing in sync2 restarts the shared count; no bit of stable updates until all bits have been quiet DB_CYCLES cycles.
REQ-014 Glitches shorter than DB_CYCLES cycles (after synchronization) never alter stable.
REQ-015 STATUS: on the edge stable is written, status<=status | (stable ^ cand) (set on either edge direction), bits held until cleared.
REQ-016 STATUS clear: We=1, Addr=1 clears each status bit whose Wd bit is 1; a bit set and cleared on the same edge ends set (set wins).
REQ-017 MASK: We=1, Addr=2 loads mask<=Wd[WIDTH-1:0]; writes to Addr 0 or 3 have no effect.
REQ-018 Rd: Addr=0 -> stable, 1 -> status, 2 -> mask, 3 -> 0; bits [31:WIDTH] read 0.
REQ-019 Irq = OR-reduction of (status & mask), combinational; asserted in the cycle after the setting edge and deasserted after the clearing edge or mask write.
REQ-020 Counter never wraps: cnt saturates at DB_CYCLES-1 while input is quiet.

Reset
REQ-021 While Reset=0: sync1, sync2, cand, stable, status, mask = 0; cnt=0; Rd reflects zeros; Irq=0.
REQ-022 Reset asserted mid-debounce discards pending cand/cnt; after release, an input held at 1 is re-debounced from scratch (DB_CYCLES+3 edges).
REQ-023 Writes with We=1 while Reset=0 are ignored.

Verification (DB_CYCLES=4, WIDTH=8)
REQ-024 Reset release, sw_in=0x00 -> Rd=0 at all Addr, Irq=0.
REQ-025 sw_in 0x00->0x05 held -> STABLE reads 0x05 after posedge 7 (not at 6); STATUS=0x05.
REQ-026 Bit 0 pulses high 3 cycles then returns low -> STABLE and STATUS unchanged.
REQ-027 MASK=0x04, STATUS=0x05 -> Irq=1; write Addr=1 Wd=0x04 -> STATUS=0x01, Irq=0; write Wd=0x01 concurrent with new bit-0 edge -> bit 0 remains 1.
REQ-028 Input change, Reset pulsed low at posedge 4 (async mid-cycle) -> all zero immediately; after release STABLE updates only after 7 further posedges.
REQ-029 Bit 3 toggles every 2 cycles while bit 1 goes high and holds -> STABLE bit 1 stays 0 until bit 3 is quiet 4 cycles.
